recharge: RTL and testbench

RECHARGE -- requirements
Module: recharge

---
 rtl/recharge.sv | 275 +++++++++++++++++++++++++++
 tb/tb_recharge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/recharge.sv
// recharge -- balance top-up editor.
//
// The user enters a 3-digit BCD amount with three debounced buttons.
// The amount is then added to the current balance one digit per cycle.
// The result is published with a one-cycle write strobe.
//
// Ports
//   clk       system clock (only clock)
//   rst       synchronous, active-high reset
//   on        block enable; 0 forces IDLE and abandons any add in progress
//   bt_pos    pulse: start edit (IDLE) / advance cursor (EDIT)
//   u_pos     pulse: increment the digit under the cursor
//   d_pos     pulse: confirm the entered amount
//   bal_in    current balance, 3-digit BCD
//   bal_out   new balance, 3-digit BCD, held between writes
//   bal_we    write strobe
//   ovf       sticky: the last write saturated at 999
//   n0..n3    display codes, n0 leftmost (0-9 digit, 10 '-', 11 blank)
//   st_light  state LEDs
//   wt_light  EDIT countdown thermometer
//
// Write strobe protocol: bal_we is high for exactly one cycle per accepted
// confirm. bal_out and ovf are valid in that same cycle. There is no
// back-pressure, so the consumer must capture on the strobe.
//
// Every output is a register. Display and light values are computed from
// the next-state values, so the LEDs and digits always match the state
// the FSM is in.
module recharge #(
  parameter int TICK      = 100000000,
  parameter int TIMEOUT_S = 8,
  parameter int SHOW_S    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        on,
  input  logic        bt_pos,
  input  logic        u_pos,
  input  logic        d_pos,
  input  logic [11:0] bal_in,
  output logic [11:0] bal_out,
  output logic        bal_we,
  output logic        ovf,
  output logic [3:0]  n0,
  output logic [3:0]  n1,
  output logic [3:0]  n2,
  output logic [3:0]  n3,
  output logic [7:0]  st_light,
  output logic [7:0]  wt_light
);

  localparam int SMAX = (TIMEOUT_S > SHOW_S) ? TIMEOUT_S : SHOW_S;
  localparam int CW   = $clog2(SMAX + 1);
  localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;

  localparam logic [CW-1:0] CNT_TO    = CW'(TIMEOUT_S);
  localparam logic [CW-1:0] CNT_SH    = CW'(SHOW_S);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);
  localparam logic [3:0]    BLANK     = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_ADD   = 3'd2,
    S_WRITE = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [11:0]   amt, amt_n;
  logic [1:0]    cursor, cursor_n;
  logic [CW-1:0] cnt, cnt_n;     // seconds left: EDIT timeout or SHOW hold
  logic [TW-1:0] tick, tick_n;
  logic [11:0]   snap, snap_n;   // bal_in captured on ADD entry
  logic [11:0]   res, res_n;
  logic [1:0]    idx, idx_n;     // digit being added, 0 = units
  logic          carry, carry_n;
  logic          sat, sat_n;

  logic [11:0]   bal_out_n;
  logic          bal_we_n, ovf_n;
  logic [3:0]    n0_n, n1_n, n2_n, n3_n;
  logic [7:0]    st_n, wt_n;

  // Working values for the current cycle's edit and add step.
  logic [3:0]    dig;
  logic [4:0]    sum;
  logic          cout;

  // Thermometer with min(c,8) low bits set.
  function automatic logic [7:0] therm(input logic [CW-1:0] c);
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t[i] = (int'(c) > i);
    return t;
  endfunction

  always_comb begin
    state_n   = state;
    amt_n     = amt;
    cursor_n  = cursor;
    cnt_n     = cnt;
    tick_n    = tick;
    snap_n    = snap;
    res_n     = res;
    idx_n     = idx;
    carry_n   = carry;
    sat_n     = sat;
    bal_out_n = bal_out;
    bal_we_n  = 1'b0;
    ovf_n     = ovf;
    dig       = amt[{cursor, 2'b00} +: 4];
    sum       = {1'b0, snap[{idx, 2'b00} +: 4]} + {1'b0, amt[{idx, 2'b00} +: 4]}
                + {4'b0, carry};
    cout      = 1'b0;
    if (sum > 5'd9) begin
      sum  = sum + 5'd6;
      cout = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (bt_pos) begin
          state_n  = S_EDIT;
          amt_n    = '0;
          cursor_n = '0;
          cnt_n    = CNT_TO;
          tick_n   = '0;
        end
      end
      S_EDIT: begin
        // The zero countdown is held for one cycle so the empty thermometer
        // is visible before the return to IDLE.
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else if (d_pos) begin
          if (amt == '0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_ADD;
            snap_n  = bal_in;
            idx_n   = '0;
            carry_n = 1'b0;
            res_n   = '0;
          end
        end else if (bt_pos) begin
          cursor_n = (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
          cnt_n    = CNT_TO;
          tick_n   = '0;
        end else if (u_pos) begin
          amt_n[{cursor, 2'b00} +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
          cnt_n    = CNT_TO;
          tick_n   = '0;
        end else if (tick == TICK_LAST) begin
          tick_n = '0;
          cnt_n  = cnt - 1'b1;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      S_ADD: begin
        res_n[{idx, 2'b00} +: 4] = sum[3:0];
        carry_n = cout;
        idx_n   = idx + 2'd1;
        if (idx == 2'd2) begin
          state_n = S_WRITE;
          sat_n   = cout;
          if (cout) res_n = 12'h999;
        end
      end
      S_WRITE: begin
        bal_we_n  = 1'b1;
        bal_out_n = res;
        ovf_n     = sat;
        state_n   = S_SHOW;
        cnt_n     = CNT_SH;
        tick_n    = '0;
      end
      S_SHOW: begin
        if (tick == TICK_LAST) begin
          tick_n = '0;
          if (cnt <= 1) state_n = S_IDLE;
          else          cnt_n   = cnt - 1'b1;
        end else begin
          tick_n = tick + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Disable wins over everything: drop to IDLE and cancel any pending write.
    if (!on) begin
      state_n   = S_IDLE;
      bal_we_n  = 1'b0;
      bal_out_n = bal_out;
      ovf_n     = ovf;
    end

    n0_n = BLANK;
    n1_n = bal_in[11:8];
    n2_n = bal_in[7:4];
    n3_n = bal_in[3:0];
    st_n = 8'b0010_0000;
    wt_n = 8'h00;
    case (state_n)
      S_IDLE: begin
        st_n = 8'b0100_0000;
        wt_n = 8'hFF;
      end
      S_EDIT: begin
        n0_n = {2'b00, cursor_n};
        n1_n = amt_n[11:8];
        n2_n = amt_n[7:4];
        n3_n = amt_n[3:0];
        st_n = 8'b1000_0000;
        wt_n = therm(cnt_n);
      end
      S_ADD: begin
        n1_n = snap_n[11:8];
        n2_n = snap_n[7:4];
        n3_n = snap_n[3:0];
      end
      default: begin
        n1_n = res_n[11:8];
        n2_n = res_n[7:4];
        n3_n = res_n[3:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      amt      <= '0;
      cursor   <= '0;
      cnt      <= CNT_TO;
      tick     <= '0;
      snap     <= '0;
      res      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sat      <= 1'b0;
      bal_out  <= '0;
      bal_we   <= 1'b0;
      ovf      <= 1'b0;
      n0       <= BLANK;
      n1       <= BLANK;
      n2       <= BLANK;
      n3       <= BLANK;
      st_light <= '0;
      wt_light <= '0;
    end else begin
      state    <= state_n;
      amt      <= amt_n;
      cursor   <= cursor_n;
      cnt      <= cnt_n;
      tick     <= tick_n;
      snap     <= snap_n;
      res      <= res_n;
      idx      <= idx_n;
      carry    <= carry_n;
      sat      <= sat_n;
      bal_out  <= bal_out_n;
      bal_we   <= bal_we_n;
      ovf      <= ovf_n;
      n0       <= n0_n;
      n1       <= n1_n;
      n2       <= n2_n;
      n3       <= n3_n;
      st_light <= st_n;
      wt_light <= wt_n;
    end
  end

endmodule

// File: tb/tb_recharge.sv
// tb_recharge -- directed bench for recharge with TICK=10.
// Confirms push {ovf, bal_out} and the strobe cycle into a queue.
// A negedge monitor pops and compares on every bal_we.
module tb_recharge;

  localparam int TICK = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        on = 1'b0;
  logic        bt_pos = 1'b0;
  logic        u_pos = 1'b0;
  logic        d_pos = 1'b0;
  logic [11:0] bal_in = 12'h000;
  logic [11:0] bal_out;
  logic        bal_we;
  logic        ovf;
  logic [3:0]  n0, n1, n2, n3;
  logic [7:0]  st_light, wt_light;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [12:0] exp_q[$];
  int          exp_cyc_q[$];

  recharge #(.TICK(TICK), .TIMEOUT_S(8), .SHOW_S(2)) dut (
    .clk(clk), .rst(rst), .on(on),
    .bt_pos(bt_pos), .u_pos(u_pos), .d_pos(d_pos),
    .bal_in(bal_in), .bal_out(bal_out), .bal_we(bal_we), .ovf(ovf),
    .n0(n0), .n1(n1), .n2(n2), .n3(n3),
    .st_light(st_light), .wt_light(wt_light)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bal_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got ovf=%b bal_out=%h expected no write", ovf, bal_out);
      end else begin
        logic [12:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        if ({ovf, bal_out} !== e || cyc != ec) begin
          miscompares++;
          $display("FAIL write: got ovf=%b bal_out=%h cyc=%0d expected ovf=%b bal_out=%h cyc=%0d",
                   ovf, bal_out, cyc, e[12], e[11:0], ec);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks: each starts anywhere and returns 1 time unit after the
  // edge that sampled the pulse.
  task automatic pulse(input int which);
    case (which)
      0: bt_pos = 1'b1;
      1: u_pos = 1'b1;
      2: d_pos = 1'b1;
      default: begin d_pos = 1'b1; u_pos = 1'b1; end
    endcase
    @(posedge clk); #1;
    bt_pos = 1'b0; u_pos = 1'b0; d_pos = 1'b0;
  endtask

  task automatic pulses(input int which, input int n);
    for (int i = 0; i < n; i++) pulse(which);
  endtask

  // Confirm and expect a write 5 counted edges after the drive point.
  task automatic confirm(input int which, input logic o, input logic [11:0] v);
    exp_q.push_back({o, v});
    exp_cyc_q.push_back(cyc + 5);
    pulse(which);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp"}, {16'h0, n0, n1, n2, n3}, 32'hBBBB);
    check({tag, "_st"}, {24'h0, st_light}, 32'h00);
    check({tag, "_wt"}, {24'h0, wt_light}, 32'h00);
    check({tag, "_bal_out"}, {20'h0, bal_out}, 32'h000);
    check({tag, "_we_ovf"}, {30'h0, bal_we, ovf}, 32'h0);
  endtask

  logic [7:0] therm_tab [0:8];

  initial begin
    therm_tab[0] = 8'hFF; therm_tab[1] = 8'h7F; therm_tab[2] = 8'h3F;
    therm_tab[3] = 8'h1F; therm_tab[4] = 8'h0F; therm_tab[5] = 8'h07;
    therm_tab[6] = 8'h03; therm_tab[7] = 8'h01; therm_tab[8] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0; on = 1'b1; bal_in = 12'h196;
    @(posedge clk); @(negedge clk);
    check("idle_disp", {16'h0, n0, n1, n2, n3}, 32'hB196);
    check("idle_st", {24'h0, st_light}, 32'h40);
    check("idle_wt", {24'h0, wt_light}, 32'hFF);

    // 196 + 024 = 220
    pulse(0);
    @(negedge clk);
    check("edit_enter_disp", {16'h0, n0, n1, n2, n3}, 32'h0000);
    check("edit_st", {24'h0, st_light}, 32'h80);
    check("edit_wt", {24'h0, wt_light}, 32'hFF);
    pulses(1, 4); pulse(0); pulses(1, 2);
    @(negedge clk);
    check("edit_024_disp", {16'h0, n0, n1, n2, n3}, 32'h1024);
    confirm(2, 1'b0, 12'h220);
    @(negedge clk);
    check("add_st", {24'h0, st_light}, 32'h20);
    check("add_wt", {24'h0, wt_light}, 32'h00);
    wait_drain(20);
    check("show_disp", {16'h0, n0, n1, n2, n3}, 32'hB220);
    wait_cycles(25);
    @(negedge clk);
    check("show_to_idle_st", {24'h0, st_light}, 32'h40);

    // 980 + 050 saturates
    bal_in = 12'h980;
    pulse(0); pulse(0); pulses(1, 5);
    @(negedge clk);
    check("edit_050_disp", {16'h0, n0, n1, n2, n3}, 32'h1050);
    confirm(2, 1'b1, 12'h999);
    wait_drain(20);
    check("sat_show_disp", {16'h0, n0, n1, n2, n3}, 32'hB999);
    wait_cycles(25);

    // Digit wrap, cursor wrap, then confirm beats increment
    bal_in = 12'h123;
    pulse(0); pulses(1, 11);
    @(negedge clk);
    check("wrap_units_disp", {16'h0, n0, n1, n2, n3}, 32'h0001);
    pulse(0);
    @(negedge clk);
    check("cursor1", {28'h0, n0}, 32'h1);
    pulse(0);
    @(negedge clk);
    check("cursor2", {28'h0, n0}, 32'h2);
    pulse(0);
    @(negedge clk);
    check("cursor_wrap", {16'h0, n0, n1, n2, n3}, 32'h0001);
    confirm(3, 1'b0, 12'h124);
    wait_drain(20);
    check("prio_show_disp", {16'h0, n0, n1, n2, n3}, 32'hB124);
    wait_cycles(25);

    // Timeout: one thermometer step per 10 cycles, then IDLE
    bal_in = 12'h500;
    pulse(0);
    @(negedge clk);
    check("timeout_wt_0", {24'h0, wt_light}, {24'h0, therm_tab[0]});
    for (int m = 1; m <= 8; m++) begin
      repeat (TICK) @(posedge clk);
      @(negedge clk);
      check($sformatf("timeout_wt_%0d", m), {24'h0, wt_light}, {24'h0, therm_tab[m]});
    end
    check("timeout_still_edit", {24'h0, st_light}, 32'h80);
    @(posedge clk); @(negedge clk);
    check("timeout_idle_st", {24'h0, st_light}, 32'h40);
    check("timeout_idle_disp", {16'h0, n0, n1, n2, n3}, 32'hB500);

    // Confirm with zero amount returns to IDLE without a write
    @(posedge clk); #1;
    pulse(0); pulse(2);
    @(negedge clk);
    check("zero_amt_idle", {24'h0, st_light}, 32'h40);

    // Reset during ADD suppresses the write
    bal_in = 12'h196;
    pulse(0); pulse(1); pulse(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_add");
    wait_cycles(10);

    // Disable during ADD also suppresses the write
    pulse(0); pulse(1); pulse(2);
    on = 1'b0;
    @(posedge clk); #1;
    on = 1'b1;
    @(negedge clk);
    check("off_idle_st", {24'h0, st_light}, 32'h40);
    wait_cycles(10);
    check("off_no_write", {31'h0, bal_we}, 32'h0);

    wait_cycles(5);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
